// File: rtl/dff.sv
// Parameterised D flip-flop pipeline with synchronous active-high reset.
// DEPTH register stages between din and dout; every stage resets to RESET_VALUE.
module dff #(
  parameter int unsigned     WIDTH       = 1,
  parameter int unsigned     DEPTH       = 1,
  // Carried wider than WIDTH so an oversized value can be caught at elaboration
  parameter logic [1023:0]   RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  localparam logic [WIDTH-1:0] ResetVal = RESET_VALUE[WIDTH-1:0];

  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $fatal(1, "dff: WIDTH must be in 1..1024");
  end
  if (DEPTH < 1 || DEPTH > 64) begin : g_bad_depth
    $fatal(1, "dff: DEPTH must be in 1..64");
  end
  if ((RESET_VALUE >> WIDTH) != '0) begin : g_bad_reset_value
    $fatal(1, "dff: RESET_VALUE does not fit in WIDTH bits");
  end

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= ResetVal;
      end
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout = stage_q[DEPTH-1];

`ifndef SYNTHESIS
  rst_known_a: assert property (@(posedge clk) !$isunknown(rst))
    else $error("dff: rst is X/Z at clock edge");

  reset_value_a: assert property (@(posedge clk) rst |=> (dout == ResetVal))
    else $error("dff: dout not RESET_VALUE after reset edge");

  if (DEPTH == 1) begin : g_single_stage_chk
    pass_through_a: assert property (@(posedge clk) !rst |=> (dout == $past(din)))
      else $error("dff: dout does not match din sampled at previous edge");
  end
`endif

endmodule

// File: tb/tb_dff.sv
// Bench for dff: a default 1-bit/1-stage instance and an 8-bit/3-stage instance
// resetting to A5, checked against a sample-history model plus literal expectations.
module tb_dff;

  logic       clk;
  logic       rst;
  logic       din1;
  logic       dout1;
  logic [7:0] din8;
  logic [7:0] dout8;

  int total;
  int bad;

  dff u_dff1 (
    .clk  (clk),
    .rst  (rst),
    .din  (din1),
    .dout (dout1)
  );

  dff #(
    .WIDTH       (8),
    .DEPTH       (3),
    .RESET_VALUE ('hA5)
  ) u_dff8 (
    .clk  (clk),
    .rst  (rst),
    .din  (din8),
    .dout (dout8)
  );

  // Rising edges at 10, 30, 50, ...
  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Model: remember what was sampled since the last reset edge. Output is the
  // reset value until DEPTH samples exist, then the sample taken DEPTH-1 edges ago.
  int         edges_since_rst = -1;
  bit         hist1[$];
  logic [7:0] hist8[$];

  always @(posedge clk) begin
    if (rst) begin
      edges_since_rst = 0;
      hist1.delete();
      hist8.delete();
    end else if (edges_since_rst >= 0) begin
      edges_since_rst++;
      hist1.push_back(din1);
      hist8.push_back(din8);
      if (hist1.size() > 8) void'(hist1.pop_front());
      if (hist8.size() > 8) void'(hist8.pop_front());
    end
  end

  function automatic logic exp1();
    if (hist1.size() < 1) return 1'b0;
    return hist1[hist1.size()-1];
  endfunction

  function automatic logic [7:0] exp8();
    if (hist8.size() < 3) return 8'hA5;
    return hist8[hist8.size()-3];
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (edges_since_rst >= 0) begin
      check("model_d1", {7'd0, dout1}, {7'd0, exp1()});
      check("model_d8", dout8, exp8());
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    din1  = 1'b0;
    din8  = 8'h00;

    #12 din1 = 1'b1;                               // t=12, pulse between edges
    #3  check("rst_d1", {7'd0, dout1}, 8'h00);    // t=15, after reset edge 10
        check("rst_d8", dout8, 8'hA5);
    #7  din1 = 1'b0;                               // t=22
    #3  rst = 1'b0; din8 = 8'h01;                 // t=25
    #10 check("glitch_d1_30", {7'd0, dout1}, 8'h00);  // t=35
        check("pipe_a5_30", dout8, 8'hA5);
    #5  din1 = 1'b1;                               // t=40
    #5  din8 = 8'h02;                              // t=45
    #10 check("hold1_50", {7'd0, dout1}, 8'h01);  // t=55
        check("pipe_a5_50", dout8, 8'hA5);
    #5  din1 = 1'b0;                               // t=60
    #5  din8 = 8'h03;                              // t=65
    #10 check("hold0_70", {7'd0, dout1}, 8'h00);  // t=75
        check("pipe_01_70", dout8, 8'h01);
    #7  din1 = 1'b1;                               // t=82, second glitch
    #3  din8 = 8'h04;                              // t=85
    #3  din1 = 1'b0;                               // t=88
    #7  check("glitch_d1_90", {7'd0, dout1}, 8'h00);  // t=95
        check("pipe_02_90", dout8, 8'h02);
    #10 din8 = 8'h05;                              // t=105
    #10 check("pipe_03_110", dout8, 8'h03);        // t=115

    // Reset for exactly the edge at 130 while 04,05,06 are in flight
    #10 rst = 1'b1; din8 = 8'h06; din1 = 1'b1;    // t=125
    #10 rst = 1'b0;                                // t=135
        check("mid_rst_130", dout8, 8'hA5);
        check("mid_rst_d1", {7'd0, dout1}, 8'h00);
    #10 din8 = 8'h10;                              // t=145
    #10 check("mid_rst_150", dout8, 8'hA5);        // t=155
    #10 din8 = 8'h11;                              // t=165
    #10 check("mid_rst_170", dout8, 8'hA5);        // t=175
    #10 din8 = 8'h12;                              // t=185
    #10 check("post_rst_190", dout8, 8'h10);       // t=195
    // rst pulse entirely between edges 190 and 210 must be ignored
    #5  rst = 1'b1;                                // t=200
    #5  rst = 1'b0; din8 = 8'h13;                 // t=205
    #10 check("rst_glitch_210", dout8, 8'h11);     // t=215
    #20 check("rst_glitch_230", dout8, 8'h12);     // t=235

    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #3;
      din1 = i[0] ^ i[2];
      din8 = 8'(i * 37 + 5);
    end
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dff.md
Name: dff

Overview:
- Single-clock, synchronously reset D flip-flop register.
- Samples `din` on every rising edge of `clk` and presents it on `dout`.
- Used as the basic storage element and as a reference block for the DPI-C scenario bench infrastructure.
- Parameterised width, pipeline depth and reset value; the defaults give a 1-bit, 1-stage DFF resetting to 0.

Parameters:
- WIDTH, 1, bit width of `din` and `dout`; legal range 1..1024.
- DEPTH, 1, number of register stages between `din` and `dout`; legal range 1..64.
- RESET_VALUE, '0 (WIDTH bits), value loaded into every stage while reset is asserted.

Ports:
- clk  input  1  clock; all state updates on the rising edge only.
- rst  input  1  reset; synchronous, active-high.
- din  input  WIDTH  data input, sampled on the rising edge of `clk`.
- dout  output  WIDTH  registered data output; driven directly from the last stage, no combinational path from `din`.

Behaviour:
- Reset is synchronous and active-high. On a rising `clk` edge with `rst`=1, every stage loads RESET_VALUE.
- `rst` changing between edges has no effect until the next rising edge; there is no asynchronous clear.
- Until the first rising edge with `rst`=1, `dout` is undefined (X in simulation). No initial-value reliance.
- After reset, every rising edge with `rst`=0 does the following:
  - stage[0] <= `din`
  - stage[i] <= stage[i-1] for i=1..DEPTH-1
  - `dout` = stage[DEPTH-1]
- Latency: `din` sampled at edge N appears on `dout` immediately after edge N+DEPTH-1.
  - DEPTH=1: visible right after the sampling edge.
  - Each additional stage adds one cycle.
- Throughput is one sample per cycle; there is no enable and no stall.
- Reset mid-stream: all stages, including in-flight data, are replaced by RESET_VALUE on the reset edge. The first post-reset `din` sample is taken on the first edge with `rst`=0.
- Simultaneous `rst`=1 and a `din` change at the same edge: reset wins and `din` is ignored for that edge.
- `din` changes between edges (glitches) never reach `dout`; only the value present at the rising edge matters.
- X or Z on `din` propagates unchanged through the stages. X on `rst` is flagged by a simulation assertion.
- Elaboration-time checks issue a fatal error when:
  - WIDTH < 1, or DEPTH < 1;
  - RESET_VALUE does not fit in WIDTH bits.
- Simulation assertions, excluded from synthesis:
  - With `rst`=1 at an edge, `dout` equals RESET_VALUE after that edge.
  - With DEPTH=1 and `rst`=0, `dout` equals the `din` value sampled at the previous edge.

Test Plan:
- Default params, `clk` period 20 (rising edges at 10, 30, 50), `rst`=1 until t=25, `din`=0 -> `dout`=0 after the edge at 10, still 0 after the edge at 30.
- Default params, `rst` released at 25, `din`=1 from t=12 to t=22, then 0 -> pulse is between edges, `dout` stays 0 at edges 30 and 50 (no mid-cycle capture).
- Default params, `din`=1 held across the edge at 50 with `rst`=0 -> `dout`=1 after 50; set `din`=0 before the edge at 70 -> `dout`=0 after 70.
- WIDTH=8, DEPTH=3, RESET_VALUE=8'hA5: feed 8'h01, 8'h02, 8'h03 on consecutive edges -> `dout` shows A5 until 8'h01 appears two edges after its sampling edge, then 02 and 03 on the following edges.
- Reset mid-stream with WIDTH=8, DEPTH=3: assert `rst` for one edge while data is in flight -> `dout`=A5 right after that edge, remaining A5 for two further edges before new data emerges.
- `rst` asserted between edges and released before the next edge -> no reset occurs and `dout` continues to track `din`.
